// File: rtl/gb_lcd_capture_pkg.sv
// Shared Game Boy LCD geometry, address width and capture FSM encoding.
// The display and readback logic import this package too.
package gb_lcd_capture_pkg;

    localparam int H_PIX_DEF          = 160;
    localparam int V_LINES_DEF        = 144;
    localparam int BYTES_PER_LINE_DEF = H_PIX_DEF / 4;
    localparam int ADDR_W             = 13;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        ACTIVE     = 2'd1,
        LINE_END   = 2'd2
    } cap_state_t;

    // GB data pins are active-low; the shade is the inverted pin pair.
    function automatic logic [1:0] pix_decode(input logic d0, input logic d1);
        return {~d0, ~d1};
    endfunction

endpackage

// File: rtl/gb_lcd_capture_sync2.sv
// Two-flop synchronizer for one asynchronous Game Boy LCD signal.
module gb_sync2 (
    input  logic clk_50,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gb_lcd_capture.sv
// Captures the Game Boy LCD pixel stream and packs four 2-bit pixels per
// display-RAM byte write, tracking line/frame structure with a small FSM.
//
// state      | meaning
// WAIT_FRAME | idle until the VSync pulse ends; no writes
// ACTIVE     | counting and packing pixels of the current line
// LINE_END   | HSync high; waiting for it to drop to open the next line
module gb_lcd_capture
    import gb_lcd_capture_pkg::*;
#(
    parameter int H_PIX          = H_PIX_DEF,
    parameter int V_LINES        = V_LINES_DEF,
    parameter int BYTES_PER_LINE = BYTES_PER_LINE_DEF
) (
    input  logic              clk_50,
    input  logic              rst_n,
    input  logic              GB_PClk,
    input  logic              GB_VSync,
    input  logic              GB_HSync,
    input  logic              GB_Data0,
    input  logic              GB_Data1,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic              line_err
);

    localparam int PIX_W  = $clog2(H_PIX + 1);
    localparam int LINE_W = $clog2(V_LINES + 1);

    logic pclk_s, vs_s, hs_s, d0_s, d1_s;
    logic pclk_q, vs_q, hs_q;
    logic pclk_rise, vs_rise, vs_fall, hs_rise, hs_fall, pix_evt;

    gb_sync2 u_sync_pclk (.clk_50(clk_50), .rst_n(rst_n), .d(GB_PClk),  .q(pclk_s));
    gb_sync2 u_sync_vs   (.clk_50(clk_50), .rst_n(rst_n), .d(GB_VSync), .q(vs_s));
    gb_sync2 u_sync_hs   (.clk_50(clk_50), .rst_n(rst_n), .d(GB_HSync), .q(hs_s));
    gb_sync2 u_sync_d0   (.clk_50(clk_50), .rst_n(rst_n), .d(GB_Data0), .q(d0_s));
    gb_sync2 u_sync_d1   (.clk_50(clk_50), .rst_n(rst_n), .d(GB_Data1), .q(d1_s));

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            pclk_q <= 1'b0;
            vs_q   <= 1'b0;
            hs_q   <= 1'b0;
        end else begin
            pclk_q <= pclk_s;
            vs_q   <= vs_s;
            hs_q   <= hs_s;
        end
    end

    assign pclk_rise = pclk_s & ~pclk_q;
    assign vs_rise   = vs_s & ~vs_q;
    assign vs_fall   = ~vs_s & vs_q;
    assign hs_rise   = hs_s & ~hs_q;
    assign hs_fall   = ~hs_s & hs_q;
    // An HSync edge in the same cycle wins; the pixel is dropped.
    assign pix_evt   = pclk_rise & ~hs_s & ~vs_s & ~hs_rise;

    cap_state_t state_q, state_d;
    logic       frame_start, line_close, line_open;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) state_q <= WAIT_FRAME;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        line_close  = 1'b0;
        line_open   = 1'b0;
        if (vs_rise) begin
            state_d = WAIT_FRAME;
        end else begin
            case (state_q)
                WAIT_FRAME: if (vs_fall) begin
                    state_d     = ACTIVE;
                    frame_start = 1'b1;
                end
                ACTIVE: if (hs_rise) begin
                    state_d    = LINE_END;
                    line_close = 1'b1;
                end
                LINE_END: if (hs_fall) begin
                    state_d   = ACTIVE;
                    line_open = 1'b1;
                end
                default: state_d = WAIT_FRAME;
            endcase
        end
    end

    logic [PIX_W-1:0]  pix_cnt;
    logic [LINE_W-1:0] line_cnt;
    logic [7:0]        pack;
    logic              byte_rdy;
    logic [ADDR_W-1:0] byte_addr;
    logic              pix_take;

    assign pix_take = (state_q == ACTIVE) && pix_evt && (pix_cnt != PIX_W'(H_PIX));

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt    <= '0;
            line_cnt   <= '0;
            pack       <= '0;
            byte_rdy   <= 1'b0;
            byte_addr  <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
        end else begin
            byte_rdy   <= 1'b0;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
            wr_en      <= byte_rdy;
            if (byte_rdy) begin
                wr_addr <= byte_addr;
                wr_data <= pack;
            end
            if (vs_rise) begin
                frame_done <= (line_cnt == LINE_W'(V_LINES));
                line_cnt   <= '0;
                pix_cnt    <= '0;
            end
            if (frame_start) begin
                line_cnt <= '0;
                pix_cnt  <= '0;
            end
            if (line_close) line_err <= (pix_cnt != PIX_W'(H_PIX));
            if (line_open) begin
                pix_cnt <= '0;
                if (line_cnt != LINE_W'(V_LINES)) line_cnt <= line_cnt + 1'b1;
            end
            if (pix_take) begin
                pix_cnt <= pix_cnt + 1'b1;
                pack    <= {pack[5:0], pix_decode(d0_s, d1_s)};
                // Lines past the frame keep counting pixels but never write.
                if (pix_cnt[1:0] == 2'd3 && line_cnt < LINE_W'(V_LINES)) begin
                    byte_rdy  <= 1'b1;
                    byte_addr <= ADDR_W'(line_cnt) * ADDR_W'(BYTES_PER_LINE)
                                 + ADDR_W'(pix_cnt >> 2);
                end
            end
        end
    end

endmodule

// File: tb/tb_gb_lcd_capture.sv
// Directed bench for gb_lcd_capture: line-segment table plus hand sequences.
`timescale 1ns/1ps
module tb_gb_lcd_capture;

    logic        clk_50 = 1'b0;
    logic        rst_n;
    logic        GB_PClk, GB_VSync, GB_HSync, GB_Data0, GB_Data1;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic        frame_done, line_err;

    gb_lcd_capture dut (
        .clk_50(clk_50), .rst_n(rst_n),
        .GB_PClk(GB_PClk), .GB_VSync(GB_VSync), .GB_HSync(GB_HSync),
        .GB_Data0(GB_Data0), .GB_Data1(GB_Data1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .line_err(line_err)
    );

    always #5 clk_50 = ~clk_50;

    int checks = 0;
    int errors = 0;

    logic [12:0] q_addr[$];
    logic [7:0]  q_data[$];
    int          err_pulses = 0;
    int          fd_pulses  = 0;
    int          total_wr   = 0;
    int          last_addr  = -1;
    int          max_addr   = -1;

    always @(posedge clk_50) begin
        #1;
        if (wr_en) begin
            q_addr.push_back(wr_addr);
            q_data.push_back(wr_data);
            total_wr++;
            last_addr = int'(wr_addr);
            if (int'(wr_addr) > max_addr) max_addr = int'(wr_addr);
        end
        if (line_err)   err_pulses++;
        if (frame_done) fd_pulses++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [1:0] pix_val(input int pat, input int i);
        logic [1:0] v;
        v = (pat == 4) ? 2'(i % 4) : 2'(pat);
        return v;
    endfunction

    task automatic set_pix(input logic [1:0] p);
        GB_Data0 = ~p[1];
        GB_Data1 = ~p[0];
    endtask

    task automatic pixel(input logic [1:0] p);
        @(negedge clk_50);
        set_pix(p);
        GB_PClk = 1'b1;
        @(negedge clk_50);
        GB_PClk = 1'b0;
    endtask

    task automatic hsync_pulse();
        repeat (6) @(negedge clk_50);
        GB_HSync = 1'b1;
        repeat (3) @(negedge clk_50);
        GB_HSync = 1'b0;
        repeat (4) @(negedge clk_50);
    endtask

    task automatic vsync_pulse();
        repeat (4) @(negedge clk_50);
        GB_VSync = 1'b1;
        repeat (3) @(negedge clk_50);
        GB_VSync = 1'b0;
        repeat (4) @(negedge clk_50);
    endtask

    task automatic clear_line();
        q_addr.delete();
        q_data.delete();
        err_pulses = 0;
    endtask

    task automatic drive_line(input int pat, input int npix);
        for (int i = 0; i < npix; i++) pixel(pix_val(pat, i));
        hsync_pulse();
    endtask

    task automatic check_line(input int line, input int exp_wr, input int exp_data, input int exp_err);
        int bad_a, bad_d;
        bad_a = 0;
        bad_d = 0;
        chk($sformatf("line%0d writes", line), q_addr.size(), exp_wr);
        foreach (q_addr[k]) begin
            if (int'(q_addr[k]) != line * 40 + k) bad_a++;
            if (int'(q_data[k]) != exp_data) bad_d++;
        end
        if (q_addr.size() > 0) begin
            chk($sformatf("line%0d first_addr", line), int'(q_addr[0]), line * 40);
            chk($sformatf("line%0d bad_addrs", line), bad_a, 0);
            chk($sformatf("line%0d bad_data(first=%0h)", line, q_data[0]), bad_d, 0);
        end
        chk($sformatf("line%0d line_err_pulses", line), err_pulses, exp_err);
    endtask

    typedef struct {
        int nlines;
        int pat;
        int npix;
        int exp_wr;
        int exp_data;
        int exp_err;
    } seg_t;

    seg_t segs[5];

    initial begin
        int line;
        int lat;

        segs[0] = '{nlines: 1,   pat: 3, npix: 160, exp_wr: 40, exp_data: 'hFF, exp_err: 0};
        segs[1] = '{nlines: 1,   pat: 2, npix: 160, exp_wr: 40, exp_data: 'hAA, exp_err: 0};
        segs[2] = '{nlines: 1,   pat: 4, npix: 160, exp_wr: 40, exp_data: 'h1B, exp_err: 0};
        segs[3] = '{nlines: 141, pat: 1, npix: 160, exp_wr: 40, exp_data: 'h55, exp_err: 0};
        segs[4] = '{nlines: 1,   pat: 0, npix: 160, exp_wr: 0,  exp_data: 'h00, exp_err: 0};

        rst_n = 1'b0;
        GB_PClk = 1'b0; GB_VSync = 1'b0; GB_HSync = 1'b0;
        GB_Data0 = 1'b0; GB_Data1 = 1'b0;
        repeat (5) @(negedge clk_50);
        chk("reset wr_en", int'(wr_en), 0);
        chk("reset wr_addr", int'(wr_addr), 0);
        chk("reset wr_data", int'(wr_data), 0);
        chk("reset frame_done", int'(frame_done), 0);
        chk("reset line_err", int'(line_err), 0);
        rst_n = 1'b1;

        // Frame A: full frame from the segment table plus one extra line.
        repeat (3) @(negedge clk_50);
        fd_pulses = 0;
        total_wr  = 0;
        vsync_pulse();
        line = 0;
        for (int s = 0; s < 5; s++) begin
            for (int n = 0; n < segs[s].nlines; n++) begin
                clear_line();
                drive_line(segs[s].pat, segs[s].npix);
                check_line(line, segs[s].exp_wr, segs[s].exp_data, segs[s].exp_err);
                line++;
            end
        end
        chk("frameA frame_done before vsync", fd_pulses, 0);
        vsync_pulse();
        chk("frameA total writes", total_wr, 5760);
        chk("frameA last addr", last_addr, 5759);
        chk("frameA max addr", max_addr, 5759);
        chk("frameA frame_done pulses", fd_pulses, 1);

        // Frame B line 0: short line of 158 pixels.
        clear_line();
        drive_line(4, 158);
        check_line(0, 39, 'h1B, 1);

        // Line 1: latency of the 4th pixel, then a pixel colliding with HSync.
        clear_line();
        for (int i = 0; i < 3; i++) pixel(2'b11);
        @(negedge clk_50);
        set_pix(2'b11);
        GB_PClk = 1'b1;
        lat = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk_50);
            #1;
            lat++;
            if (wr_en) break;
        end
        chk("latency pclk->wr_en cycles", lat, 4);
        @(negedge clk_50);
        GB_PClk = 1'b0;
        for (int i = 4; i < 159; i++) pixel(2'b11);
        repeat (6) @(negedge clk_50);
        set_pix(2'b11);
        GB_PClk  = 1'b1;
        GB_HSync = 1'b1;
        @(negedge clk_50);
        GB_PClk = 1'b0;
        repeat (3) @(negedge clk_50);
        GB_HSync = 1'b0;
        repeat (4) @(negedge clk_50);
        check_line(1, 39, 'hFF, 1);

        // Lines 2..49, then reset in the middle of line 50.
        for (int l = 2; l < 50; l++) drive_line(3, 160);
        for (int i = 0; i < 80; i++) pixel(2'b11);
        @(negedge clk_50);
        rst_n = 1'b0;
        #1;
        chk("midreset wr_en", int'(wr_en), 0);
        chk("midreset wr_addr", int'(wr_addr), 0);
        chk("midreset wr_data", int'(wr_data), 0);
        repeat (3) @(negedge clk_50);
        rst_n = 1'b1;
        clear_line();
        fd_pulses = 0;
        for (int i = 80; i < 160; i++) pixel(2'b11);
        hsync_pulse();
        drive_line(3, 160);
        chk("post-reset writes before vsync", q_addr.size(), 0);
        vsync_pulse();
        chk("post-reset frame_done pulses", fd_pulses, 0);
        clear_line();
        drive_line(2, 160);
        check_line(0, 40, 'hAA, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
